// File: rtl/product_readout_if.sv
// product_readout_if
//   Valid/ready stream carrying one A-column of the product array per beat.
//   master (producer) drives data/index/valid/last, slave (sink) drives ready.
//   Signals:
//     out_data   [DIM_C-1:0][ACC_WIDTH-1:0]  one word per product row
//     out_idx    [IDX_W-1:0]                 column index of this beat
//     out_valid                              beat valid
//     out_last                               final beat of the frame
//     out_ready                              sink accepts beat
interface product_readout_if #(
  parameter int DIM_C     = 4,
  parameter int DIM_A     = 4,
  parameter int ACC_WIDTH = 16
);
  localparam int IDX_W = (DIM_A > 1) ? $clog2(DIM_A) : 1;

  logic [DIM_C-1:0][ACC_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]                out_idx;
  logic                            out_valid;
  logic                            out_last;
  logic                            out_ready;

  modport master (
    output out_data, out_idx, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_idx, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/product_readout.sv
// product_readout
//   Captures the DIM_C x DIM_A product array when start is seen in IDLE, then
//   streams it out one column per beat. The captured copy lets the array
//   producer keep overwriting prod_in while the frame is read out.
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous reset, active-high
//     start      request readout of the current prod_in
//     prod_in    [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] product array
//     out_if     stream master (out_data/out_idx/out_valid/out_last, out_ready)
//     busy       high whenever not IDLE
//     done       one-cycle pulse after the final beat is accepted
//     start_err  one-cycle pulse when start arrives while busy
module product_readout #(
  parameter int DIM_C     = 4,
  parameter int DIM_A     = 4,
  parameter int ACC_WIDTH = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] prod_in,
  product_readout_if.master                          out_if,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       start_err
);
  localparam int IDX_W = (DIM_A > 1) ? $clog2(DIM_A) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM_A - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                                     state_reg;
  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] snap_reg;
  logic [IDX_W-1:0]                           idx_reg;
  logic [IDX_W-1:0]                           idx_next;
  logic                                       valid_reg;
  logic                                       last_reg;
  logic                                       busy_reg;
  logic                                       done_reg;
  logic                                       start_err_reg;

  assign idx_next = idx_reg + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      snap_reg      <= '0;
      idx_reg       <= '0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      start_err_reg <= 1'b0;
    end else begin
      done_reg      <= 1'b0;
      start_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            snap_reg  <= prod_in;
            idx_reg   <= '0;
            valid_reg <= 1'b1;
            // With a single column the first beat is also the last one.
            last_reg  <= (DIM_A == 1);
            busy_reg  <= 1'b1;
            state_reg <= STREAM;
          end
        end
        STREAM: begin
          if (start) start_err_reg <= 1'b1;
          if (valid_reg && out_if.out_ready) begin
            if (idx_reg == LAST_IDX) begin
              idx_reg   <= '0;
              valid_reg <= 1'b0;
              last_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              idx_reg  <= idx_next;
              last_reg <= (idx_next == LAST_IDX);
            end
          end
        end
        DONE: begin
          // done is high for this single cycle; busy drops on return to IDLE.
          if (start) start_err_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Column mux: out_data follows idx_reg, so it only moves on a handshake.
  genvar gi;
  generate
    for (gi = 0; gi < DIM_C; gi++) begin : g_col_mux
      assign out_if.out_data[gi] = snap_reg[gi][idx_reg];
    end
  endgenerate

  assign out_if.out_idx   = idx_reg;
  assign out_if.out_valid = valid_reg;
  assign out_if.out_last  = last_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign start_err        = start_err_reg;
endmodule

// File: tb/tb_product_readout.sv
module tb_product_readout;
  localparam int DC = 4;
  localparam int DA = 4;
  localparam int AW = 16;
  localparam int IW = 2;

  typedef logic [DC-1:0][DA-1:0][AW-1:0] arr_t;
  typedef logic [DC-1:0][AW-1:0]         beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  arr_t prod_in = '0;
  logic busy, done, start_err;

  int checks = 0;
  int errors = 0;

  product_readout_if #(.DIM_C(DC), .DIM_A(DA), .ACC_WIDTH(AW)) sif ();

  product_readout #(.DIM_C(DC), .DIM_A(DA), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prod_in   (prod_in),
    .out_if    (sif),
    .busy      (busy),
    .done      (done),
    .start_err (start_err)
  );

  always #5 clk = ~clk;

  // Reference model: beat j of a frame is column j of the array captured at start.
  function automatic beat_t column(input arr_t a, input int j);
    beat_t b;
    for (int c = 0; c < DC; c++) b[c] = a[c][j];
    return b;
  endfunction

  function automatic arr_t rand_arr();
    arr_t a;
    for (int c = 0; c < DC; c++)
      for (int j = 0; j < DA; j++) a[c][j] = AW'($urandom);
    return a;
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input arr_t a);
    prod_in = a;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    arr_t a;
    repeat (2) step();
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", sif.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0 || start_err !== 1'b0) begin errors++; $display("FAIL rst_pulses got done=%b err=%b want 0 0", done, start_err); end
    checks++; if (sif.out_idx !== '0 || sif.out_last !== 1'b0) begin errors++; $display("FAIL rst_idx got idx=%0d last=%b want 0 0", sif.out_idx, sif.out_last); end
    checks++; if (sif.out_data !== '0) begin errors++; $display("FAIL rst_data got %h want 0", sif.out_data); end
    rst = 1'b0;
    step();
    // Abandon a frame at beat 2 with an asynchronous reset.
    a = rand_arr();
    sif.out_ready = 1'b1;
    run_start(a);
    step();
    step();
    checks++; if (sif.out_idx !== IW'(2)) begin errors++; $display("FAIL rst_mid_pre got idx=%0d want 2", sif.out_idx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sif.out_idx !== '0) begin
      errors++; $display("FAIL rst_async got valid=%b busy=%b done=%b idx=%0d want 0 0 0 0", sif.out_valid, busy, done, sif.out_idx);
    end
    repeat (2) begin
      step();
      checks++; if (done !== 1'b0 || sif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold got done=%b valid=%b want 0 0", done, sif.out_valid); end
    end
    rst = 1'b0;
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_after got done=%b busy=%b want 0 0", done, busy); end
    $display("transaction: reset mid-frame abandoned cleanly");
  endtask

  task automatic test_full_rate();
    arr_t a;
    for (int f = 0; f < 3; f++) begin
      if (f == 0) begin
        for (int c = 0; c < DC; c++)
          for (int j = 0; j < DA; j++) a[c][j] = AW'(16 * c + j);
      end else begin
        a = rand_arr();
      end
      sif.out_ready = 1'b1;
      run_start(a);
      for (int j = 0; j < DA; j++) begin
        checks++; if (sif.out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL fr_valid j=%0d got valid=%b busy=%b want 1 1", j, sif.out_valid, busy); end
        checks++; if (sif.out_idx !== IW'(j)) begin errors++; $display("FAIL fr_idx got %0d want %0d", sif.out_idx, j); end
        checks++; if (sif.out_data !== column(a, j)) begin errors++; $display("FAIL fr_data j=%0d got %h want %h", j, sif.out_data, column(a, j)); end
        checks++; if (sif.out_last !== (j == DA - 1)) begin errors++; $display("FAIL fr_last j=%0d got %b want %b", j, sif.out_last, (j == DA - 1)); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fr_early_done j=%0d got 1 want 0", j); end
        $display("transaction: frame %0d beat %0d data=%h", f, j, sif.out_data);
        step();
      end
      checks++; if (done !== 1'b1 || sif.out_valid !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL fr_done got done=%b valid=%b busy=%b want 1 0 1", done, sif.out_valid, busy);
      end
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fr_idle got done=%b busy=%b want 0 0", done, busy); end
    end
  endtask

  task automatic test_backpressure();
    arr_t a;
    int dones;
    a = rand_arr();
    sif.out_ready = 1'b1;
    run_start(a);
    step();
    sif.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (sif.out_valid !== 1'b1 || sif.out_idx !== IW'(1) || sif.out_data !== column(a, 1)) begin
        errors++; $display("FAIL bp_hold k=%0d got valid=%b idx=%0d data=%h want 1 1 %h", k, sif.out_valid, sif.out_idx, sif.out_data, column(a, 1));
      end
      step();
    end
    sif.out_ready = 1'b1;
    for (int j = 1; j < DA; j++) begin
      checks++; if (sif.out_idx !== IW'(j) || sif.out_data !== column(a, j)) begin
        errors++; $display("FAIL bp_resume got idx=%0d data=%h want %0d %h", sif.out_idx, sif.out_data, j, column(a, j));
      end
      step();
    end
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      if (done === 1'b1) dones++;
      step();
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", dones); end
    $display("transaction: backpressured frame, done pulses=%0d", dones);
  endtask

  task automatic test_random_ready();
    arr_t a;
    int j;
    int cyc;
    bit rdy;
    for (int f = 0; f < 4; f++) begin
      a = rand_arr();
      run_start(a);
      j = 0;
      cyc = 0;
      while (j < DA && cyc < 200) begin
        checks++; if (sif.out_valid !== 1'b1 || sif.out_idx !== IW'(j) || sif.out_data !== column(a, j) || sif.out_last !== (j == DA - 1)) begin
          errors++; $display("FAIL rr_beat got valid=%b idx=%0d data=%h last=%b want 1 %0d %h %b", sif.out_valid, sif.out_idx, sif.out_data, sif.out_last, j, column(a, j), (j == DA - 1));
        end
        rdy = 1'($urandom_range(0, 1));
        sif.out_ready = rdy;
        prod_in = rand_arr();
        step();
        if (rdy) j++;
        cyc++;
      end
      checks++; if (cyc >= 200) begin errors++; $display("FAIL rr_timeout got %0d cycles want <200", cyc); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rr_done got %b want 1", done); end
      $display("transaction: random-ready frame %0d in %0d cycles", f, cyc);
      step();
    end
    sif.out_ready = 1'b1;
  endtask

  task automatic test_snapshot();
    arr_t a;
    a = rand_arr();
    sif.out_ready = 1'b1;
    run_start(a);
    prod_in = '1;
    for (int j = 0; j < DA; j++) begin
      checks++; if (sif.out_data !== column(a, j)) begin errors++; $display("FAIL snap_data j=%0d got %h want %h", j, sif.out_data, column(a, j)); end
      step();
    end
    step();
    $display("transaction: snapshot frame isolated from prod_in");
  endtask

  task automatic test_start_busy();
    arr_t a;
    a = rand_arr();
    sif.out_ready = 1'b1;
    run_start(a);
    step();
    step();
    prod_in = rand_arr();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (start_err !== 1'b1) begin errors++; $display("FAIL sb_err_stream got %b want 1", start_err); end
    checks++; if (sif.out_idx !== IW'(3) || sif.out_data !== column(a, 3)) begin
      errors++; $display("FAIL sb_frame got idx=%0d data=%h want 3 %h", sif.out_idx, sif.out_data, column(a, 3));
    end
    step();
    checks++; if (done !== 1'b1 || start_err !== 1'b0) begin errors++; $display("FAIL sb_done got done=%b err=%b want 1 0", done, start_err); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (start_err !== 1'b1 || busy !== 1'b0 || sif.out_valid !== 1'b0) begin
      errors++; $display("FAIL sb_err_done got err=%b busy=%b valid=%b want 1 0 0", start_err, busy, sif.out_valid);
    end
    step();
    checks++; if (sif.out_valid !== 1'b0 || start_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL sb_no_frame got valid=%b err=%b busy=%b want 0 0 0", sif.out_valid, start_err, busy);
    end
    $display("transaction: start while busy rejected twice");
  endtask

  task automatic test_back_to_back();
    arr_t a;
    arr_t b;
    a = rand_arr();
    b = rand_arr();
    sif.out_ready = 1'b1;
    run_start(a);
    repeat (DA) step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
    step();
    run_start(b);
    for (int j = 0; j < DA; j++) begin
      checks++; if (sif.out_valid !== 1'b1 || sif.out_idx !== IW'(j) || sif.out_data !== column(b, j)) begin
        errors++; $display("FAIL b2b_beat got valid=%b idx=%0d data=%h want 1 %0d %h", sif.out_valid, sif.out_idx, sif.out_data, j, column(b, j));
      end
      step();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", done); end
    step();
    $display("transaction: back-to-back frames");
  endtask

  initial begin
    sif.out_ready = 1'b0;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_random_ready();
    test_snapshot();
    test_start_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
